motor_countdown_timer: RTL and testbench

// - Upstream stage of the motor output gate. Holds the motor run time as two BCD digits (tens, ones of seconds).
// - Counts the time down once per second while running. Its digits drive the gate's i_sec_10/i_sec_1 inputs and the FND display.
// - The gate forces the motor off at 00. This block also stops itself at 00 and pulses o_done.

---
 rtl/motor_countdown_timer.sv | 112 +++++++++++
 tb/tb_motor_countdown_timer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/motor_countdown_timer.sv
// Two-digit BCD motor run timer: counts down once per second while running, stops and pulses o_done at 00.
// All outputs registered (pulse at edge N visible after edge N); no backpressure, every input pulse is accepted.
module motor_countdown_timer #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int STEP_SEC = 10
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_add,
    input  logic       i_run_toggle,
    input  logic       i_clear,
    output logic [3:0] o_sec_10,
    output logic [3:0] o_sec_1,
    output logic       o_running,
    output logic       o_done
);

    localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [7:0]    STEP      = 8'(STEP_SEC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;

    logic          tick;
    logic [6:0]    cur_val;
    logic [6:0]    dec_val;
    logic [7:0]    sum_val;
    logic [6:0]    nxt_val;
    logic [3:0]    nxt_tens;
    logic [3:0]    nxt_ones;

    // Arithmetic is done on the binary equivalent, then split back into BCD,
    // so tick and add in the same cycle compose as sat99(value - 1 + STEP).
    always_comb begin
        tick    = (state == RUN) && (presc == PRESC_MAX);
        cur_val = {3'b000, o_sec_10} * 7'd10 + {3'b000, o_sec_1};
        dec_val = cur_val;
        if (tick && (cur_val != 7'd0)) begin
            dec_val = cur_val - 7'd1;
        end
        sum_val = {1'b0, dec_val};
        if (i_add) begin
            sum_val = sum_val + STEP;
        end
        nxt_val  = (sum_val > 8'd99) ? 7'd99 : sum_val[6:0];
        nxt_tens = 4'(nxt_val / 7'd10);
        nxt_ones = 4'(nxt_val % 7'd10);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            presc     <= '0;
            o_sec_10  <= 4'd0;
            o_sec_1   <= 4'd0;
            o_running <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_clear) begin
                state     <= IDLE;
                presc     <= '0;
                o_sec_10  <= 4'd0;
                o_sec_1   <= 4'd0;
                o_running <= 1'b0;
            end else begin
                o_sec_10 <= nxt_tens;
                o_sec_1  <= nxt_ones;
                case (state)
                    IDLE: begin
                        // Start decision uses the pre-add time, so add+toggle from 00 stays idle.
                        if (i_run_toggle && (cur_val != 7'd0)) begin
                            state     <= RUN;
                            o_running <= 1'b1;
                            presc     <= '0;
                        end
                    end
                    RUN: begin
                        presc <= tick ? '0 : presc + PW'(1);
                        if (tick && (nxt_val == 7'd0)) begin
                            state     <= IDLE;
                            o_running <= 1'b0;
                            o_done    <= 1'b1;
                        end else if (i_run_toggle) begin
                            state     <= PAUSE;
                            o_running <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        // Prescaler holds here so a resume finishes the partial second.
                        if (i_run_toggle) begin
                            state     <= RUN;
                            o_running <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        o_running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motor_countdown_timer.sv
// Directed bench for motor_countdown_timer with CLK_HZ = 10, STEP_SEC = 10.
module tb_motor_countdown_timer;

    logic       clk;
    logic       rst_n;
    logic       add;
    logic       run_toggle;
    logic       clear;
    logic [3:0] sec_10;
    logic [3:0] sec_1;
    logic       running;
    logic       done;

    int checks = 0;
    int errors = 0;

    motor_countdown_timer #(
        .CLK_HZ  (10),
        .STEP_SEC(10)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_add       (add),
        .i_run_toggle(run_toggle),
        .i_clear     (clear),
        .o_sec_10    (sec_10),
        .o_sec_1     (sec_1),
        .o_running   (running),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] t, input logic [3:0] o,
                           input logic r, input logic d);
        chk({tag, "_tens"}, 32'(sec_10), 32'(t));
        chk({tag, "_ones"}, 32'(sec_1), 32'(o));
        chk({tag, "_running"}, 32'(running), 32'(r));
        chk({tag, "_done"}, 32'(done), 32'(d));
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_add();
        add = 1'b1;
        cyc();
        add = 1'b0;
    endtask

    task automatic pulse_toggle();
        run_toggle = 1'b1;
        cyc();
        run_toggle = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        add        = 1'b0;
        run_toggle = 1'b0;
        clear      = 1'b0;
        repeat (2) cyc();
        chk_all("reset", 4'd0, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc();

        // Two adds, start, first decrement exactly 10 cycles after RUN entry.
        pulse_add();
        pulse_add();
        chk_all("load20", 4'd2, 4'd0, 1'b0, 1'b0);
        pulse_toggle();
        chk_all("start20", 4'd2, 4'd0, 1'b1, 1'b0);
        repeat (9) cyc();
        chk_all("pre_tick", 4'd2, 4'd0, 1'b1, 1'b0);
        cyc();
        chk_all("first_tick", 4'd1, 4'd9, 1'b1, 1'b0);
        pulse_clear();
        chk_all("clear1", 4'd0, 4'd0, 1'b0, 1'b0);

        // Countdown 10 -> 00 with a single-cycle done pulse.
        pulse_add();
        pulse_toggle();
        repeat (90) cyc();
        chk_all("at01", 4'd0, 4'd1, 1'b1, 1'b0);
        repeat (9) cyc();
        chk_all("at01_late", 4'd0, 4'd1, 1'b1, 1'b0);
        cyc();
        chk_all("reach00", 4'd0, 4'd0, 1'b0, 1'b1);
        cyc();
        chk_all("done_drop", 4'd0, 4'd0, 1'b0, 1'b0);
        pulse_toggle();
        chk_all("toggle_at00", 4'd0, 4'd0, 1'b0, 1'b0);
        add        = 1'b1;
        run_toggle = 1'b1;
        cyc();
        add        = 1'b0;
        run_toggle = 1'b0;
        chk_all("add_toggle_00", 4'd1, 4'd0, 1'b0, 1'b0);
        cyc();
        chk_all("add_toggle_00_hold", 4'd1, 4'd0, 1'b0, 1'b0);

        // Pause after 4 cycles, freeze 50 cycles, resume finishes the partial second.
        pulse_add();
        pulse_toggle();
        repeat (3) cyc();
        pulse_toggle();
        chk_all("paused", 4'd2, 4'd0, 1'b0, 1'b0);
        repeat (50) cyc();
        chk_all("pause_frozen", 4'd2, 4'd0, 1'b0, 1'b0);
        pulse_toggle();
        chk_all("resumed", 4'd2, 4'd0, 1'b1, 1'b0);
        repeat (5) cyc();
        chk_all("resume_pre", 4'd2, 4'd0, 1'b1, 1'b0);
        cyc();
        chk_all("resume_tick", 4'd1, 4'd9, 1'b1, 1'b0);
        pulse_clear();

        // Saturation at 99, then 95 + 10 -> 99 while paused.
        for (int i = 0; i < 10; i++) pulse_add();
        chk_all("sat_99", 4'd9, 4'd9, 1'b0, 1'b0);
        pulse_add();
        chk_all("sat_hold", 4'd9, 4'd9, 1'b0, 1'b0);
        pulse_toggle();
        repeat (40) cyc();
        chk_all("at95", 4'd9, 4'd5, 1'b1, 1'b0);
        pulse_toggle();
        chk_all("pause95", 4'd9, 4'd5, 1'b0, 1'b0);
        pulse_add();
        chk_all("add95", 4'd9, 4'd9, 1'b0, 1'b0);
        pulse_clear();

        // Add on the same cycle as the tick that would reach 00.
        pulse_add();
        pulse_toggle();
        repeat (99) cyc();
        chk_all("tickadd_pre", 4'd0, 4'd1, 1'b1, 1'b0);
        pulse_add();
        chk_all("tickadd", 4'd1, 4'd0, 1'b1, 1'b0);
        cyc();
        chk_all("tickadd_after", 4'd1, 4'd0, 1'b1, 1'b0);
        pulse_clear();

        // Clear mid-run at 15.
        pulse_add();
        pulse_add();
        pulse_toggle();
        repeat (50) cyc();
        chk_all("at15", 4'd1, 4'd5, 1'b1, 1'b0);
        pulse_clear();
        chk_all("clear15", 4'd0, 4'd0, 1'b0, 1'b0);
        cyc();
        chk_all("clear15_after", 4'd0, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-run, observed before any clock edge.
        pulse_add();
        pulse_toggle();
        repeat (3) cyc();
        chk_all("pre_arst", 4'd1, 4'd0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst", 4'd0, 4'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
